pmd901_spi_master: RTL and testbench

PMD901_SPI_MASTER -- requirements
Module: pmd901_spi_master

---
 rtl/pmd901_agent_dec.sv | 14 +
 rtl/pmd901_sync2.sv | 24 ++
 rtl/pmd901_spi_master.sv | 152 +++++++++++++++
 tb/tb_pmd901_spi_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmd901_agent_dec.sv
// Shared declarations for the PMD901 SPI master: frame width and FSM state encoding.
package pmd901_agent_dec;

   localparam int unsigned PMD901_WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

endpackage

// File: rtl/pmd901_sync2.sv
// Two-flop synchronizer for an asynchronous PMD901 status pin.
module pmd901_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pmd901_spi_master.sv
// PMD901 motor driver SPI master: sends 16-bit speed words (CPOL=0, MSB first)
// and drives the park/bend pins, which only change while chip select is idle.
module pmd901_spi_master
   import pmd901_agent_dec::*;
#(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned CSN_SETUP = 2,
   parameter int unsigned CSN_HOLD  = 2,
   parameter int unsigned MIN_IDLE  = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_speed,
   input  logic        park_req,
   input  logic        bend_req,
   output logic        spi_clk,
   output logic        spi_csn,
   output logic        spi_mosi,
   output logic        park,
   output logic        bend,
   input  logic        fault,
   input  logic        fan,
   input  logic        ready,
   output logic        st_fault,
   output logic        st_fan,
   output logic        st_ready,
   output logic        busy
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned CNT_W = 8;

   spi_state_e                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [DIV_W-1:0]           div_q, div_d;
   logic [3:0]                 bit_q, bit_d;
   logic [PMD901_WORD_W-1:0]   sh_q, sh_d;
   logic                       sclk_q, sclk_d;
   logic                       csn_q, csn_d;
   logic                       park_q, park_d;
   logic                       bend_q, bend_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         csn_q   <= 1'b1;
         park_q  <= 1'b0;
         bend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sclk_q  <= sclk_d;
         csn_q   <= csn_d;
         park_q  <= park_d;
         bend_q  <= bend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      sclk_d  = sclk_q;
      csn_d   = csn_q;
      // Pins follow requests only while csn is (registered) high, so a frame never sees them move.
      park_d  = csn_q ? park_req : park_q;
      bend_d  = csn_q ? bend_req : bend_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d = SETUP;
               sh_d    = cmd_speed;
               csn_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         SETUP: begin
            if (cnt_q == CNT_W'(CSN_SETUP - 1)) begin
               state_d = SHIFT;
               sclk_d  = 1'b1;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            // The 16th low phase runs to completion before HOLD starts.
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
               div_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  sh_d   = {sh_q[PMD901_WORD_W-2:0], 1'b0};
               end else if (bit_q == 4'd15) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end else begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(CSN_HOLD - 1)) begin
               state_d = GAP;
               csn_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(MIN_IDLE - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE) && park_q;
      busy      = (state_q != IDLE);
      spi_clk   = sclk_q;
      spi_csn   = csn_q;
      spi_mosi  = csn_q ? 1'b0 : sh_q[PMD901_WORD_W-1];
      park      = park_q;
      bend      = bend_q;
   end

   pmd901_sync2 u_sync_fault (.clk_i(clk), .rst_ni(rstn), .d_i(fault), .q_o(st_fault));
   pmd901_sync2 u_sync_fan   (.clk_i(clk), .rst_ni(rstn), .d_i(fan),   .q_o(st_fan));
   pmd901_sync2 u_sync_ready (.clk_i(clk), .rst_ni(rstn), .d_i(ready), .q_o(st_ready));

endmodule

// File: tb/tb_pmd901_spi_master.sv
// Directed bench for pmd901_spi_master with a small SPI receiver sampling mosi on spi_clk rise.
module tb_pmd901_spi_master;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_speed = '0;
   logic        park_req = 1'b0;
   logic        bend_req = 1'b0;
   logic        fault = 1'b0;
   logic        fan = 1'b0;
   logic        ready = 1'b0;
   logic        cmd_ready, spi_clk, spi_csn, spi_mosi, park, bend;
   logic        st_fault, st_fan, st_ready, busy;

   int          errors = 0;
   int          checks = 0;

   logic [15:0] rx_sh = '0;
   int unsigned rx_bits = 0;

   always #5 clk = ~clk;

   always @(posedge spi_clk) begin
      if (!spi_csn) begin
         rx_sh   <= {rx_sh[14:0], spi_mosi};
         rx_bits <= rx_bits + 1;
      end
   end

   pmd901_spi_master #(
      .CLK_DIV  (4),
      .CSN_SETUP(2),
      .CSN_HOLD (2),
      .MIN_IDLE (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_speed(cmd_speed),
      .park_req (park_req),
      .bend_req (bend_req),
      .spi_clk  (spi_clk),
      .spi_csn  (spi_csn),
      .spi_mosi (spi_mosi),
      .park     (park),
      .bend     (bend),
      .fault    (fault),
      .fan      (fan),
      .ready    (ready),
      .st_fault (st_fault),
      .st_fan   (st_fan),
      .st_ready (st_ready),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake one word, optionally toggle bend_req once bend_bit rising edges have gone by,
   // and return at the first negedge where csn is seen high again.
   task automatic send(input logic [15:0] w, input int bend_bit,
                       output int low_cyc, output int unsigned nbits);
      int unsigned base;
      int          n;
      bit          toggled;
      cmd_speed = w;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("hs_ready", cmd_ready, 1);
      @(posedge clk);
      base = rx_bits;
      #1 cmd_valid = 1'b0;
      chk("csn_fall", spi_csn, 0);
      chk("mosi_msb", spi_mosi, w[15]);
      low_cyc = 0;
      toggled = 1'b0;
      @(negedge clk);
      while (spi_csn == 1'b0 && low_cyc < 400) begin
         if (!toggled && bend_bit >= 0 && int'(rx_bits - base) == bend_bit) begin
            bend_req = ~bend_req;
            toggled  = 1'b1;
         end
         low_cyc++;
         @(negedge clk);
      end
      nbits = rx_bits - base;
   endtask

   initial begin
      int          lc;
      int unsigned nb;
      int          bad;
      int          gap;
      int          n;
      int unsigned base;
      logic [5:0]  st_hist;

      // Reset values, with a status pin already high to show the synchronizer is held
      ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_csn", spi_csn, 1);
      chk("rst_sclk", spi_clk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_park", park, 0);
      chk("rst_bend", bend, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_st_ready", st_ready, 0);

      // Release with park requested: no cmd_ready before park is high
      rstn = 1'b1;
      park_req = 1'b1;
      #1 chk("rel_cmd_ready", cmd_ready, 0);
      @(negedge clk);
      chk("rel_park", park, 1);
      chk("rel_cmd_ready_after_park", cmd_ready, 1);
      @(negedge clk);
      chk("st_ready_sync", st_ready, 1);

      // Plain frame: A5C3
      send(16'hA5C3, -1, lc, nb);
      chk("a5c3_len", lc, 132);
      chk("a5c3_bits", nb, 16);
      chk("a5c3_word", rx_sh, 16'hA5C3);
      chk("a5c3_bend_normal", bend, 0);
      chk("a5c3_busy_gap", busy, 1);
      repeat (6) @(negedge clk);
      chk("a5c3_idle", busy, 0);

      // Parked: commands refused for 500 cycles
      park_req = 1'b0;
      @(negedge clk);
      chk("park_low", park, 0);
      cmd_speed = 16'hDEAD;
      cmd_valid = 1'b1;
      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (cmd_ready !== 1'b0 || spi_csn !== 1'b1 || busy !== 1'b0) bad++;
      end
      cmd_valid = 1'b0;
      chk("parked_no_frame", bad, 0);
      park_req = 1'b1;
      @(negedge clk);
      chk("unpark", park, 1);

      // Bend requested mid-frame takes effect one cycle after csn rise
      send(16'hFFFF, 5, lc, nb);
      chk("ffff_word", rx_sh, 16'hFFFF);
      chk("ffff_len", lc, 132);
      chk("bend_at_csn_rise", bend, 0);
      @(negedge clk);
      chk("bend_one_after", bend, 1);

      // Back-to-back with cmd_valid held
      repeat (6) @(negedge clk);
      cmd_speed = 16'h0001;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_speed = 16'h8000;
      n = 0;
      @(negedge clk);
      while (spi_csn == 1'b0 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_first_word", rx_sh, 16'h0001);
      gap = 0;
      while (spi_csn == 1'b1 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("b2b_gap", gap, 5);
      n = 0;
      while (spi_csn == 1'b0 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_second_word", rx_sh, 16'h8000);

      // Reset mid-frame at bit 8 of 1234
      repeat (6) @(negedge clk);
      cmd_speed = 16'h1234;
      cmd_valid = 1'b1;
      @(posedge clk);
      base = rx_bits;
      #1 cmd_valid = 1'b0;
      n = 0;
      while (rx_bits - base < 8 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_bit8", rx_bits - base, 8);
      rstn = 1'b0;
      #1;
      chk("abort_csn", spi_csn, 1);
      chk("abort_sclk", spi_clk, 0);
      chk("abort_busy", busy, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("abort_park_cleared", park, 0);
      chk("abort_no_ready", cmd_ready, 0);
      send(16'h00FF, -1, lc, nb);
      chk("00ff_word", rx_sh, 16'h00FF);
      chk("00ff_bits", nb, 16);
      chk("00ff_len", lc, 132);

      // Status synchronizers: 3-cycle fault pulse, fan held
      repeat (6) @(negedge clk);
      fault = 1'b1;
      fan = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         st_hist[k] = st_fault;
         if (k == 2) fault = 1'b0;
      end
      chk("st_fault_pulse", st_hist, 6'b001110);
      chk("st_fan_sync", st_fan, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
